// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
//
// Hits return the instruction combinationally in the same cycle. A miss raises
// stall, latches the line base and refills the whole line one word at a time
// over a mem_req/mem_ack handshake. The lookup is then retried.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   inv             invalidate all lines
//   pc_req/pc_addr  fetch request and byte address (bits [1:0] ignored)
//   inst, stall     fetched word (valid when pc_req && !stall), fetch hold
//   mem_req/addr    registered word read request to backing memory
//   mem_ack/rdata   word return, sampled only while mem_req is high
//   hit_cnt/miss_cnt  (only with ICACHE_STATS_EN) hit/miss event counters
//
// Optional feature macro: ICACHE_STATS_EN adds the two statistics counters.
module icache_dm #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv,
  input  logic        pc_req,
  input  logic [31:0] pc_addr,
  output logic [31:0] inst,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [0:0] ST_LOOKUP = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  logic [0:0]       state;
  logic [OFF_W-1:0] cnt;
  logic [TAG_W-1:0] ref_tag;
  logic [IDX_W-1:0] ref_idx;
  logic             abort;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES][WORDS];

  // Address split of the current fetch
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       unused_byte;

  assign off         = pc_addr[2 +: OFF_W];
  assign idx         = pc_addr[2 + OFF_W +: IDX_W];
  assign tag         = pc_addr[31 -: TAG_W];
  assign unused_byte = pc_addr[1:0];

  logic             lookup, tag_hit, hit, miss, last, wr_en;
  logic [OFF_W-1:0] cnt_nxt;

  assign lookup  = !rst && pc_req && (state == ST_LOOKUP);
  assign tag_hit = valid[idx] && (tag_arr[idx] == tag);
  assign hit     = lookup && tag_hit;
  assign miss    = lookup && !tag_hit;
  assign last    = (cnt == OFF_W'(WORDS - 1));
  assign cnt_nxt = cnt + OFF_W'(1);
  // A returned word is only accepted while a request is actually outstanding
  assign wr_en   = !rst && (state == ST_REFILL) && mem_req && mem_ack;

  assign stall = !rst && (miss || (state == ST_REFILL));
  assign inst  = hit ? data_arr[idx][off] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOOKUP;
      cnt      <= '0;
      ref_tag  <= '0;
      ref_idx  <= '0;
      abort    <= 1'b0;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
    end else begin
      // The lookup in this cycle has already used the old valid bits
      if (inv) valid <= '0;
      case (state)
        ST_LOOKUP: begin
          if (miss) begin
            ref_tag <= tag;
            ref_idx <= idx;
            cnt     <= '0;
            state   <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          // Never drop the memory handshake on inv; just refuse to validate
          if (inv) abort <= 1'b1;
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {ref_tag, ref_idx, {OFF_W{1'b0}}, 2'b00};
          end else if (mem_ack) begin
            if (last) begin
              mem_req <= 1'b0;
              cnt     <= '0;
              abort   <= 1'b0;
              state   <= ST_LOOKUP;
              if (!abort && !inv) valid[ref_idx] <= 1'b1;
            end else begin
              cnt      <= cnt_nxt;
              mem_addr <= {ref_tag, ref_idx, cnt_nxt, 2'b00};
            end
          end
        end
        default: state <= ST_LOOKUP;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_arr[ref_idx][cnt] <= mem_rdata;
      if (last) tag_arr[ref_idx] <= ref_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      // miss only asserts in LOOKUP, so this counts LOOKUP->REFILL edges
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm (LINES=8, WORDS=4).
// A behavioural memory acks each request `lat` cycles after it is presented
// and checks requested addresses against a queue of expected addresses.
module tb_icache_dm;
  localparam int LINES = 8;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst, inv, pc_req;
  logic [31:0] pc_addr, inst, mem_addr, mem_rdata;
  logic        stall, mem_req, mem_ack;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .inv(inv), .pc_req(pc_req), .pc_addr(pc_addr),
    .inst(inst), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int lat = 2;
  int req_cycles = 0;
  logic [31:0] exp_addr_q[$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic push_line(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'(WORDS * 4 - 1);
    for (int w = 0; w < WORDS; w++) exp_addr_q.push_back(b + 32'(4 * w));
  endtask

  // Backing memory: acks when a request has been visible for `lat` cycles
  initial begin : mem_model
    bit busy;
    int age;
    logic [31:0] cur, e;
    busy = 0; age = 0; cur = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst === 1'b0) begin
        req_cycles++;
        if (!busy || mem_addr != cur) begin
          busy = 1; cur = mem_addr; age = 0;
          if (exp_addr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_mem_req: got addr %h expected no request", cur);
          end else begin
            e = exp_addr_q.pop_front();
            chk("mem_addr_seq", cur, e);
          end
        end else age++;
        mem_ack   = (age >= lat - 1);
        mem_rdata = mw(cur);
      end else begin
        busy = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // Fetch that is expected to miss; optionally pulses inv once when the
  // refill presents inv_at (and, if on_ack, when that word is acked).
  task automatic fetch(input string nm, input logic [31:0] a, input int exp_n,
                       input logic [31:0] inv_at, input bit on_ack);
    int n;
    bit fired;
    n = 0; fired = 0;
    pc_req = 1'b1; pc_addr = a;
    samp();
    while (stall && n < 400) begin
      n++;
      if (inv_at != 0 && !fired && mem_req && mem_addr == inv_at && (!on_ack || mem_ack)) begin
        inv = 1'b1; fired = 1;
      end
      nxt();
      inv = 1'b0;
      samp();
    end
    chk({nm, "_stall_cycles"}, n, exp_n);
    chk({nm, "_inst"}, inst, mw(a & ~32'h3));
    nxt();
  endtask

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          stall;
    logic [31:0] inst;
  } vec_t;
  vec_t vecs[6];

  task automatic apply_vecs(input int lo, input int hi);
    int rc;
    rc = req_cycles;
    for (int i = lo; i <= hi; i++) begin
      pc_req = vecs[i].req; pc_addr = vecs[i].addr;
      samp();
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].stall);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].inst);
      nxt();
    end
    chk("vec_no_mem_req", req_cycles, rc);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    vecs[0] = '{1'b1, 32'h44, 1'b0, mw(32'h44)};
    vecs[1] = '{1'b1, 32'h48, 1'b0, mw(32'h48)};
    vecs[2] = '{1'b1, 32'h4C, 1'b0, mw(32'h4C)};
    vecs[3] = '{1'b0, 32'h40, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 32'h43, 1'b0, mw(32'h40)};
    vecs[5] = '{1'b1, 32'h4E, 1'b0, mw(32'h4C)};

    // Reset: outputs quiet even with a fetch pending
    rst = 1'b1; inv = 1'b0; pc_req = 1'b1; pc_addr = 32'h40;
    nxt(); nxt();
    samp();
    chk("rst_stall", stall, 1'b0);
    chk("rst_inst", inst, 32'h0);
    nxt();
    rst = 1'b0; pc_req = 1'b0;
    samp();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("idle_stall", stall, 1'b0);
    nxt();

    // Cold fetch: 1 + WORDS*2 + 1 stall cycles
    push_line(32'h40);
    fetch("cold_40", 32'h40, 10, 32'h0, 1'b0);

    // Sequential hits, no memory traffic
    apply_vecs(0, 2);
`ifdef ICACHE_STATS_EN
    chk("stats_miss_cnt", miss_cnt, 32'd1);
    chk("stats_hit_cnt", hit_cnt, 32'd4);
`endif
    apply_vecs(3, 5);

    // Conflict miss on the same index, then the evicted line misses again
    push_line(32'h140);
    fetch("conflict_140", 32'h140, 10, 32'h0, 1'b0);
    push_line(32'h40);
    fetch("conflict_40", 32'h40, 10, 32'h0, 1'b0);

    // Single-cycle memory latency
    lat = 1;
    push_line(32'h1A0);
    fetch("lat1_1a0", 32'h1A4, 6, 32'h0, 1'b0);
    lat = 2;

    // inv during 2nd word: line finishes but stays invalid, so it refills twice
    push_line(32'h80); push_line(32'h80);
    fetch("inv_mid_80", 32'h80, 20, 32'h84, 1'b0);

    // inv in LOOKUP: current lookup still hits, next one misses
    pc_req = 1'b1; pc_addr = 32'h88; inv = 1'b1;
    samp();
    chk("inv_lookup_stall", stall, 1'b0);
    chk("inv_lookup_inst", inst, mw(32'h88));
    nxt();
    inv = 1'b0;
    push_line(32'h80);
    fetch("inv_lookup_refetch", 32'h88, 10, 32'h0, 1'b0);

    // inv on the same edge as the last-word ack
    push_line(32'hC0); push_line(32'hC0);
    fetch("inv_last_c0", 32'hC0, 20, 32'hCC, 1'b1);

    // Reset after the first ack of a refill
    exp_addr_q.push_back(32'h100);
    pc_req = 1'b1; pc_addr = 32'h100;
    n = 0;
    samp();
    while (!(mem_req && mem_ack) && n < 50) begin
      n++; nxt(); samp();
    end
    chk("rstmid_first_ack", mem_ack, 1'b1);
    nxt();
    rst = 1'b1;
    samp();
    chk("rstmid_stall", stall, 1'b0);
    chk("rstmid_inst", inst, 32'h0);
    nxt();
    rst = 1'b0; pc_req = 1'b0;
    samp();
    chk("rstmid_mem_req_drop", mem_req, 1'b0);
    chk("rstmid_queue_empty", exp_addr_q.size(), 32'd0);
    nxt();
    push_line(32'h100);
    fetch("rstmid_refetch_100", 32'h100, 10, 32'h0, 1'b0);

    pc_req = 1'b0;
    nxt(); nxt();
    chk("final_queue_empty", exp_addr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
